// File: rtl/xike_stat_pkg.sv
// Shared constants for the status register bank: read address map, counter widths
// and STATUS word bit positions.
package xike_stat_pkg;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned CNT_W  = 32;
    localparam int unsigned DROP_W = 16;
    localparam int unsigned TS_W   = 32;

    localparam logic [ADDR_W-1:0] ADDR_SAMPLE_LO = 5'd0;
    localparam logic [ADDR_W-1:0] ADDR_SAMPLE_HI = 5'd1;
    localparam logic [ADDR_W-1:0] ADDR_SPIKE_LO  = 5'd2;
    localparam logic [ADDR_W-1:0] ADDR_SPIKE_HI  = 5'd3;
    localparam logic [ADDR_W-1:0] ADDR_DROP      = 5'd4;
    localparam logic [ADDR_W-1:0] ADDR_STATUS    = 5'd5;
    localparam logic [ADDR_W-1:0] ADDR_TS_LO     = 5'd6;
    localparam logic [ADDR_W-1:0] ADDR_TS_HI     = 5'd7;

    localparam int unsigned STS_SMP_OVF  = 0;
    localparam int unsigned STS_SPK_OVF  = 1;
    localparam int unsigned STS_DROP_SAT = 2;
    localparam int unsigned STS_EOF      = 3;
    localparam int unsigned STS_THR_EN   = 4;
    localparam int unsigned STS_VER_LSB  = 8;

endpackage

// File: rtl/stat_counter.sv
// Wrapping accumulator with a sticky overflow flag; clear has priority over increment.
module stat_counter #(
    parameter int unsigned W     = 32,
    parameter int unsigned INC_W = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [INC_W-1:0] inc_i,
    output logic [W-1:0]     cnt_o,
    output logic             ovf_o
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         ovf_q, ovf_d;
    logic [W:0]   inc_ext;
    logic [W:0]   sum;

    assign inc_ext = {{(W + 1 - INC_W){1'b0}}, inc_i};
    assign sum     = {1'b0, cnt_q} + inc_ext;

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (clr_i) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (en_i) begin
            // Carry out of the top bit wraps the count and latches the flag.
            cnt_d = sum[W-1:0];
            ovf_d = ovf_q | sum[W];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt_o = cnt_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/stat_reg_16.sv
// Host-readable status bank: sample/spike/drop counters with coherent snapshot on SAMPLE_LO read.
// Optional timestamp counter enabled by defining STAT_TIMESTAMP_EN.
module stat_reg_16
    import xike_stat_pkg::*;
#(
    parameter int unsigned SPK_W   = 6,
    parameter logic [7:0]  VERSION = 8'h01
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              smp_vld_i,
    input  logic [SPK_W-1:0]  spk_inc_i,
    input  logic              drop_vld_i,
    input  logic              thr_en_i,
    input  logic              eof_i,
    input  logic              clr_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic [DATA_W-1:0] dout_o
);

    logic [CNT_W-1:0]  smp_cnt, spk_cnt;
    logic              smp_ovf, spk_ovf;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic              drop_sat_q, drop_sat_d;
    logic [15:0]       smp_sh_hi_q;
    logic [CNT_W-1:0]  spk_sh_q;
    logic [DROP_W-1:0] drop_sh_q;
    logic [DATA_W-1:0] status;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              snap;

    assign snap = re_i && (addr_i == ADDR_SAMPLE_LO);

    stat_counter #(
        .W     (CNT_W),
        .INC_W (1)
    ) u_smp_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (clr_i),
        .en_i  (!eof_i),
        .inc_i (smp_vld_i),
        .cnt_o (smp_cnt),
        .ovf_o (smp_ovf)
    );

    stat_counter #(
        .W     (CNT_W),
        .INC_W (SPK_W)
    ) u_spk_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (clr_i),
        .en_i  (thr_en_i && !eof_i),
        .inc_i (spk_inc_i),
        .cnt_o (spk_cnt),
        .ovf_o (spk_ovf)
    );

    // Drops keep counting through eof; the flag marks a drop lost to saturation.
    always_comb begin
        drop_d     = drop_q;
        drop_sat_d = drop_sat_q;
        if (clr_i) begin
            drop_d     = '0;
            drop_sat_d = 1'b0;
        end else if (drop_vld_i) begin
            if (drop_q == {DROP_W{1'b1}}) begin
                drop_sat_d = 1'b1;
            end else begin
                drop_d = drop_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            drop_q     <= '0;
            drop_sat_q <= 1'b0;
        end else begin
            drop_q     <= drop_d;
            drop_sat_q <= drop_sat_d;
        end
    end

`ifdef STAT_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q, ts_sh_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ts_sh_q <= '0;
        end else if (snap) begin
            ts_sh_q <= ts_q;
        end
    end
`endif

    // Shadows take the pre-clear values when clr coincides with a snapshot.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            smp_sh_hi_q <= '0;
            spk_sh_q    <= '0;
            drop_sh_q   <= '0;
        end else if (snap) begin
            smp_sh_hi_q <= smp_cnt[31:16];
            spk_sh_q    <= spk_cnt;
            drop_sh_q   <= drop_q;
        end
    end

    always_comb begin
        status                        = '0;
        status[STS_VER_LSB +: 8]      = VERSION;
        status[STS_THR_EN]            = thr_en_i;
        status[STS_EOF]               = eof_i;
        status[STS_DROP_SAT]          = drop_sat_q;
        status[STS_SPK_OVF]           = spk_ovf;
        status[STS_SMP_OVF]           = smp_ovf;
    end

    always_comb begin
        rd_data = '0;
        case (addr_i)
            ADDR_SAMPLE_LO: rd_data = smp_cnt[15:0];
            ADDR_SAMPLE_HI: rd_data = smp_sh_hi_q;
            ADDR_SPIKE_LO:  rd_data = spk_sh_q[15:0];
            ADDR_SPIKE_HI:  rd_data = spk_sh_q[31:16];
            ADDR_DROP:      rd_data = drop_sh_q;
            ADDR_STATUS:    rd_data = status;
`ifdef STAT_TIMESTAMP_EN
            ADDR_TS_LO:     rd_data = ts_sh_q[15:0];
            ADDR_TS_HI:     rd_data = ts_sh_q[31:16];
`endif
            default:        rd_data = '0;
        endcase
    end

    assign dout_d = re_i ? rd_data : dout_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dout_q <= '0;
        end else begin
            dout_q <= dout_d;
        end
    end

    assign dout_o = dout_q;

endmodule

// File: tb/tb_stat_reg_16.sv
// Self-checking bench for stat_reg_16 plus a narrow stat_counter instance for wrap corners.
module tb_stat_reg_16;

    logic        clk;
    logic        rst;
    logic        smp_vld;
    logic [5:0]  spk_inc;
    logic        drop_vld;
    logic        thr_en;
    logic        eof;
    logic        clr;
    logic        re;
    logic [4:0]  addr;
    logic [15:0] dout;

    logic        sc_clr;
    logic        sc_en;
    logic [5:0]  sc_inc;
    logic [7:0]  sc_cnt;
    logic        sc_ovf;

    int total;
    int bad;

    typedef struct {
        string       name;
        logic [15:0] exp;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        logic [4:0]  a;
        logic [15:0] exp;
    } rd_vec_t;
    rd_vec_t rst_tab[32];

    typedef struct {
        logic       clr;
        logic       en;
        logic [5:0] inc;
        logic [7:0] cnt;
        logic       ovf;
    } sc_vec_t;
    sc_vec_t sc_tab[11];

    stat_reg_16 #(
        .SPK_W   (6),
        .VERSION (8'h01)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .smp_vld_i  (smp_vld),
        .spk_inc_i  (spk_inc),
        .drop_vld_i (drop_vld),
        .thr_en_i   (thr_en),
        .eof_i      (eof),
        .clr_i      (clr),
        .re_i       (re),
        .addr_i     (addr),
        .dout_o     (dout)
    );

    stat_counter #(
        .W     (8),
        .INC_W (6)
    ) u_sc (
        .clk_i (clk),
        .rst_i (rst),
        .clr_i (sc_clr),
        .en_i  (sc_en),
        .inc_i (sc_inc),
        .cnt_o (sc_cnt),
        .ovf_o (sc_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Issue a read; the expected word enters the scoreboard and is retired one cycle later.
    task automatic rd(input logic [4:0] a, input logic [15:0] exp, input string nm,
                      input logic with_clr);
        sb_t e;
        addr = a;
        re   = 1'b1;
        clr  = with_clr;
        sb_q.push_back('{nm, exp});
        tick();
        re  = 1'b0;
        clr = 1'b0;
        e   = sb_q.pop_front();
        chk(e.name, {16'h0, dout}, {16'h0, e.exp});
    endtask

    task automatic run(input int n, input logic s, input logic d);
        smp_vld  = s;
        drop_vld = d;
        repeat (n) tick();
        smp_vld  = 1'b0;
        drop_vld = 1'b0;
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1; smp_vld = 1'b0; spk_inc = '0; drop_vld = 1'b0; thr_en = 1'b0;
        eof = 1'b0; clr = 1'b0; re = 1'b1; addr = 5'd5;
        sc_clr = 1'b0; sc_en = 1'b0; sc_inc = '0;

        // Reset table: addr 0 last so its snapshot cannot disturb the other reads.
        for (int i = 0; i < 32; i++) begin
            rst_tab[i].a   = 5'((i + 1) % 32);
            rst_tab[i].exp = (rst_tab[i].a == 5'd5) ? 16'h0100 : 16'h0000;
        end
        sc_tab[0]  = '{1'b1, 1'b0, 6'd0,  8'd0,   1'b0};
        sc_tab[1]  = '{1'b0, 1'b1, 6'd63, 8'd63,  1'b0};
        sc_tab[2]  = '{1'b0, 1'b1, 6'd63, 8'd126, 1'b0};
        sc_tab[3]  = '{1'b0, 1'b1, 6'd63, 8'd189, 1'b0};
        sc_tab[4]  = '{1'b0, 1'b1, 6'd63, 8'd252, 1'b0};
        sc_tab[5]  = '{1'b0, 1'b1, 6'd10, 8'd6,   1'b1};
        sc_tab[6]  = '{1'b0, 1'b0, 6'd63, 8'd6,   1'b1};
        sc_tab[7]  = '{1'b0, 1'b1, 6'd0,  8'd6,   1'b1};
        sc_tab[8]  = '{1'b1, 1'b1, 6'd5,  8'd0,   1'b0};
        sc_tab[9]  = '{1'b0, 1'b1, 6'd63, 8'd63,  1'b0};
        sc_tab[10] = '{1'b0, 1'b1, 6'd63, 8'd126, 1'b0};

        repeat (3) tick();
        chk("dout_in_reset", {16'h0, dout}, 32'h0);
        rst = 1'b0;
        re  = 1'b0;
        tick();

        for (int i = 0; i < 32; i++) begin
            rd(rst_tab[i].a, rst_tab[i].exp, $sformatf("reset_addr%0d", rst_tab[i].a), 1'b0);
        end

        // Sample counting and eof freeze.
        run(1000, 1'b1, 1'b0);
        rd(5'd0, 16'h03E8, "smp_lo_1000", 1'b0);
        rd(5'd1, 16'h0000, "smp_hi_1000", 1'b0);
        addr = 5'd5;
        repeat (3) tick();
        chk("dout_hold", {16'h0, dout}, 32'h0000_0000);
        eof = 1'b1;
        run(10, 1'b1, 1'b0);
        rd(5'd0, 16'h03E8, "smp_frozen_eof", 1'b0);
        rd(5'd5, 16'h0108, "status_eof", 1'b0);
        eof = 1'b0;

        // Spike counting: enable, disable, eof freeze.
        thr_en = 1'b1; spk_inc = 6'd63;
        repeat (10) tick();
        spk_inc = 6'd0;
        rd(5'd5, 16'h0110, "status_thr_en", 1'b0);
        rd(5'd0, 16'h03E8, "snap_smp", 1'b0);
        rd(5'd2, 16'h0276, "spk_lo_630", 1'b0);
        rd(5'd3, 16'h0000, "spk_hi_630", 1'b0);
        thr_en = 1'b0; spk_inc = 6'd63;
        repeat (5) tick();
        eof = 1'b1; thr_en = 1'b1;
        repeat (5) tick();
        eof = 1'b0; thr_en = 1'b0; spk_inc = 6'd0;
        rd(5'd0, 16'h03E8, "snap_smp2", 1'b0);
        rd(5'd2, 16'h0276, "spk_gated", 1'b0);

        // clr alongside snapshot: shadows keep pre-clear values.
        rd(5'd0, 16'h03E8, "snap_with_clr", 1'b1);
        rd(5'd2, 16'h0276, "shadow_preclear", 1'b0);
        rd(5'd0, 16'h0000, "smp_after_clr", 1'b0);
        // clr beats simultaneous increments.
        clr = 1'b1; smp_vld = 1'b1; thr_en = 1'b1; spk_inc = 6'd5; drop_vld = 1'b1;
        tick();
        clr = 1'b0; smp_vld = 1'b0; thr_en = 1'b0; spk_inc = 6'd0; drop_vld = 1'b0;
        rd(5'd0, 16'h0000, "clr_beats_smp", 1'b0);
        rd(5'd2, 16'h0000, "clr_beats_spk", 1'b0);
        rd(5'd4, 16'h0000, "clr_beats_drop", 1'b0);
        rd(5'd5, 16'h0100, "clr_flags", 1'b0);

        // 16-bit boundary of SAMPLE, shadow coherence, DROP saturation.
        run(65535, 1'b1, 1'b1);
        rd(5'd0, 16'hFFFF, "smp_lo_ffff", 1'b0);
        rd(5'd1, 16'h0000, "smp_hi_ffff", 1'b0);
        rd(5'd4, 16'hFFFF, "drop_ffff", 1'b0);
        run(5, 1'b1, 1'b1);
        rd(5'd1, 16'h0000, "smp_hi_shadow", 1'b0);
        rd(5'd0, 16'h0004, "smp_lo_10004", 1'b0);
        rd(5'd1, 16'h0001, "smp_hi_10004", 1'b0);
        run(4460, 1'b0, 1'b1);
        rd(5'd0, 16'h0004, "snap_after_drops", 1'b0);
        rd(5'd4, 16'hFFFF, "drop_saturated", 1'b0);
        rd(5'd5, 16'h0104, "status_drop_sat", 1'b0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        rd(5'd0, 16'h0000, "snap_after_clr2", 1'b0);
        rd(5'd4, 16'h0000, "drop_after_clr", 1'b0);
        rd(5'd5, 16'h0100, "status_after_clr", 1'b0);

        // Timestamp: TS is 0 right after the clr edge and counts one per cycle.
        clr = 1'b1;
        tick();
        clr = 1'b0;
        repeat (37) tick();
        rd(5'd0, 16'h0000, "ts_snap", 1'b0);
`ifdef STAT_TIMESTAMP_EN
        rd(5'd6, 16'd37, "ts_lo", 1'b0);
`else
        rd(5'd6, 16'h0000, "ts_lo_absent", 1'b0);
`endif
        rd(5'd7, 16'h0000, "ts_hi", 1'b0);

        // Narrow counter: wrap, sticky overflow, gating, clear priority.
        for (int i = 0; i < 11; i++) begin
            sc_clr = sc_tab[i].clr;
            sc_en  = sc_tab[i].en;
            sc_inc = sc_tab[i].inc;
            tick();
            chk($sformatf("sc_cnt_%0d", i), {24'h0, sc_cnt}, {24'h0, sc_tab[i].cnt});
            chk($sformatf("sc_ovf_%0d", i), {31'h0, sc_ovf}, {31'h0, sc_tab[i].ovf});
        end
        sc_clr = 1'b0; sc_en = 1'b0; sc_inc = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
